// File: rtl/bus_sequencer_pkg.sv
// Shared types and slot offsets for the CPU/MCU bus sequencer.
// Slot offsets count clk16_i cycles from the start of a CPU cycle.
package bus_sequencer_pkg;

    localparam int BUS_AW       = 17;
    localparam int STROBE_START = 1;
    localparam int WE_START     = 2;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } seq_state_e;

    // Last cycle that RAM strobes are held, and also the read-data sample point.
    function automatic int sample_off(input int cpu_div);
        return cpu_div / 2 - 2;
    endfunction

    // Completion slot: the final cycle of phi1.
    function automatic int done_off(input int cpu_div);
        return cpu_div / 2 - 1;
    endfunction

endpackage

// File: rtl/cpu_phase_counter.sv
// Counts clk16_i cycles within one CPU cycle and generates the registered phi0.
// The ld_* pulses flag the edge that is about to load a given count.
module cpu_phase_counter
    import bus_sequencer_pkg::*;
#(
    parameter  int CPU_DIV = 16,
    localparam int CW      = $clog2(CPU_DIV)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic [CW-1:0] o_cnt,
    output logic          o_cpu_clk,
    output logic          o_ld_zero,
    output logic          o_at_sample,
    output logic          o_ld_done
);

    localparam int            HALF     = CPU_DIV / 2;
    localparam logic [CW-1:0] C_LAST   = CW'(CPU_DIV - 1);
    localparam logic [CW-1:0] C_HALF   = CW'(HALF);
    localparam logic [CW-1:0] C_SAMPLE = CW'(sample_off(CPU_DIV));
    localparam logic [CW-1:0] C_DONE   = CW'(done_off(CPU_DIV));

    logic [CW-1:0] w_cnt_nxt;

    assign w_cnt_nxt   = (o_cnt == C_LAST) ? '0 : o_cnt + CW'(1);
    assign o_ld_zero   = (w_cnt_nxt == '0);
    assign o_at_sample = (o_cnt == C_SAMPLE);
    assign o_ld_done   = (w_cnt_nxt == C_DONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cnt     <= '0;
            o_cpu_clk <= 1'b0;
        end else begin
            o_cnt     <= w_cnt_nxt;
            o_cpu_clk <= (w_cnt_nxt >= C_HALF);
        end
    end

endmodule

// File: rtl/bus_sequencer.sv
// Time-shares the system bus: MCU transactions in phi1, 6502 owns the bus in phi2.
// Optional macro CPU_HALT_EN enables cpu_halt_i -> cpu_ready_o (updated at cnt = 0 only).
module bus_sequencer
    import bus_sequencer_pkg::*;
#(
    parameter int CPU_DIV = 16
) (
    input  logic              clk16_i,
    input  logic              reset_ni,
    input  logic              mcu_req_i,
    input  logic              mcu_we_i,
    input  logic [BUS_AW-1:0] mcu_addr_i,
    input  logic [7:0]        mcu_wr_data_i,
    output logic [7:0]        mcu_rd_data_o,
    output logic              mcu_done_o,
    input  logic              cpu_halt_i,
    output logic              cpu_clk_o,
    output logic              cpu_be_o,
    output logic              cpu_ready_o,
    output logic [BUS_AW-1:0] bus_addr_o,
    output logic              bus_addr_oe,
    input  logic [7:0]        bus_data_i,
    output logic [7:0]        bus_data_o,
    output logic              bus_data_oe,
    output logic              bus_rw_no,
    output logic              bus_rw_noe,
    output logic              ram_ce_no,
    output logic              ram_oe_no,
    output logic              ram_we_no
);

    localparam int            CW       = $clog2(CPU_DIV);
    localparam logic [CW-1:0] C_WE_OFS = CW'(WE_START - STROBE_START);

    generate
        if ((CPU_DIV % 2) != 0 || CPU_DIV < 8) begin : g_bad_div
            $error("bus_sequencer: CPU_DIV must be even and >= 8");
        end
    endgenerate

    logic [CW-1:0] w_cnt;
    logic          w_ld_zero;
    logic          w_at_sample;
    logic          w_ld_done;
    seq_state_e    r_state;
    logic          r_we;

    cpu_phase_counter #(.CPU_DIV(CPU_DIV)) u_phase (
        .i_clk       (clk16_i),
        .i_rst_n     (reset_ni),
        .o_cnt       (w_cnt),
        .o_cpu_clk   (cpu_clk_o),
        .o_ld_zero   (w_ld_zero),
        .o_at_sample (w_at_sample),
        .o_ld_done   (w_ld_done)
    );

    always_ff @(posedge clk16_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state       <= IDLE;
            r_we          <= 1'b0;
            mcu_done_o    <= 1'b0;
            mcu_rd_data_o <= '0;
            cpu_be_o      <= 1'b0;
            bus_addr_o    <= '0;
            bus_addr_oe   <= 1'b0;
            bus_data_o    <= '0;
            bus_data_oe   <= 1'b0;
            bus_rw_no     <= 1'b1;
            bus_rw_noe    <= 1'b0;
            ram_ce_no     <= 1'b1;
            ram_oe_no     <= 1'b1;
            ram_we_no     <= 1'b1;
        end else begin
            // Bus released to the CPU unless a transaction overrides below.
            mcu_done_o  <= 1'b0;
            cpu_be_o    <= 1'b1;
            bus_addr_oe <= 1'b0;
            bus_data_oe <= 1'b0;
            bus_rw_no   <= 1'b1;
            bus_rw_noe  <= 1'b0;
            ram_ce_no   <= 1'b1;
            ram_oe_no   <= 1'b1;
            ram_we_no   <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_ld_zero && mcu_req_i) begin
                        r_state     <= XFER;
                        r_we        <= mcu_we_i;
                        bus_addr_o  <= mcu_addr_i;
                        bus_data_o  <= mcu_wr_data_i;
                        cpu_be_o    <= 1'b0;
                        bus_addr_oe <= 1'b1;
                        bus_rw_noe  <= 1'b1;
                        bus_rw_no   <= !mcu_we_i;
                    end
                end
                XFER: begin
                    cpu_be_o    <= 1'b0;
                    bus_addr_oe <= 1'b1;
                    bus_rw_noe  <= 1'b1;
                    bus_rw_no   <= !r_we;
                    bus_data_oe <= r_we;
                    if (w_ld_done) begin
                        mcu_done_o <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        ram_ce_no <= 1'b0;
                        ram_oe_no <= r_we;
                        // Write strobe starts one slot after CE so address is settled.
                        ram_we_no <= !(r_we && (w_cnt >= C_WE_OFS));
                    end
                    if (w_at_sample && !r_we) begin
                        mcu_rd_data_o <= bus_data_i;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CPU_HALT_EN
    // RDY only moves at the start of phi1, so it is stable through phi2.
    always_ff @(posedge clk16_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cpu_ready_o <= 1'b1;
        end else if (w_ld_zero) begin
            cpu_ready_o <= !cpu_halt_i;
        end
    end
`else
    logic w_unused_halt;
    assign w_unused_halt = cpu_halt_i;

    always_ff @(posedge clk16_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cpu_ready_o <= 1'b1;
        end else begin
            cpu_ready_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer (CPU_DIV = 16); expected control vectors come
// from a per-slot model keyed on a bench-side cycle counter.
module tb_bus_sequencer;

    logic        clk16_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        mcu_req_i = 1'b0;
    logic        mcu_we_i = 1'b0;
    logic [16:0] mcu_addr_i = '0;
    logic [7:0]  mcu_wr_data_i = '0;
    logic [7:0]  mcu_rd_data_o;
    logic        mcu_done_o;
    logic        cpu_halt_i = 1'b0;
    logic        cpu_clk_o, cpu_be_o, cpu_ready_o;
    logic [16:0] bus_addr_o;
    logic        bus_addr_oe;
    logic [7:0]  bus_data_i = '0;
    logic [7:0]  bus_data_o;
    logic        bus_data_oe, bus_rw_no, bus_rw_noe;
    logic        ram_ce_no, ram_oe_no, ram_we_no;

    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;
    int m_cnt = 0;

    localparam logic [9:0] RST_CTL = 10'b00000_11110;

    bus_sequencer #(.CPU_DIV(16)) dut (
        .clk16_i       (clk16_i),
        .reset_ni      (reset_ni),
        .mcu_req_i     (mcu_req_i),
        .mcu_we_i      (mcu_we_i),
        .mcu_addr_i    (mcu_addr_i),
        .mcu_wr_data_i (mcu_wr_data_i),
        .mcu_rd_data_o (mcu_rd_data_o),
        .mcu_done_o    (mcu_done_o),
        .cpu_halt_i    (cpu_halt_i),
        .cpu_clk_o     (cpu_clk_o),
        .cpu_be_o      (cpu_be_o),
        .cpu_ready_o   (cpu_ready_o),
        .bus_addr_o    (bus_addr_o),
        .bus_addr_oe   (bus_addr_oe),
        .bus_data_i    (bus_data_i),
        .bus_data_o    (bus_data_o),
        .bus_data_oe   (bus_data_oe),
        .bus_rw_no     (bus_rw_no),
        .bus_rw_noe    (bus_rw_noe),
        .ram_ce_no     (ram_ce_no),
        .ram_oe_no     (ram_oe_no),
        .ram_we_no     (ram_we_no)
    );

    always #5 clk16_i = ~clk16_i;

    always @(posedge clk16_i or negedge reset_ni) begin
        if (!reset_ni) m_cnt <= 0;
        else           m_cnt <= (m_cnt + 1) % 16;
    end

    wire [9:0] w_ctl = {cpu_clk_o, cpu_be_o, bus_addr_oe, bus_data_oe, bus_rw_noe,
                        bus_rw_no, ram_ce_no, ram_oe_no, ram_we_no, mcu_done_o};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t cnt=%0d)", tag, got, exp, $time, m_cnt);
        end
    endtask

    // Expected control outputs for slot c; x = this frame carries a transaction.
    function automatic logic [9:0] exp_ctl(input bit x, input bit we, input int c);
        bit ph2, act;
        ph2 = (c >= 8);
        act = x && !ph2;
        return {ph2, !act, act, act && we && c >= 1, act, !(act && we),
                !(act && c >= 1 && c <= 6), !(act && !we && c >= 1 && c <= 6),
                !(act && we && c >= 2 && c <= 6), act && c == 7};
    endfunction

    task automatic step();
        @(negedge clk16_i);
    endtask

    task automatic cyc(input bit x, input bit we, input logic [16:0] a, input logic [7:0] d,
                       input string tag);
        chk(tag, w_ctl, exp_ctl(x, we, m_cnt));
        if (x && m_cnt < 8) chk({tag, "_addr"}, bus_addr_o, a);
        if (x && we && m_cnt >= 1 && m_cnt < 8) chk({tag, "_wdat"}, bus_data_o, d);
        if (mcu_done_o) n_done++;
    endtask

    task automatic wait_cnt(input int c);
        int k = 0;
        step();
        while (m_cnt != c && k < 40) begin
            step();
            k++;
        end
        if (m_cnt != c) chk("wait_cnt", m_cnt, c);
    endtask

    initial begin
        int  dpos[$];
        bit  exp_rdy, prev_halt;

        // Reset state
        repeat (3) step();
        chk("rst_ctl", w_ctl, RST_CTL);
        chk("rst_rdy", cpu_ready_o, 1);
        chk("rst_rd", mcu_rd_data_o, 0);
        chk("rst_addr", bus_addr_o, 0);
        chk("rst_wdat", bus_data_o, 0);
        reset_ni = 1'b1;

        // 1: free-running, no requests
        repeat (32) begin step(); cyc(0, 0, '0, '0, "idle"); end

        // 2: write raised at cnt 5 waits for the next cnt 0
        wait_cnt(5);
        mcu_req_i = 1; mcu_we_i = 1; mcu_addr_i = 17'h08000; mcu_wr_data_i = 8'hA5;
        n_done = 0;
        repeat (10) begin step(); cyc(0, 1, '0, '0, "wr_wait"); end
        repeat (16) begin
            step();
            cyc(1, 1, 17'h08000, 8'hA5, "wr");
            if (m_cnt == 3) begin mcu_addr_i = 17'h01234; mcu_wr_data_i = 8'hFF; end
            if (m_cnt == 7) mcu_req_i = 0;
        end
        chk("wr_done_cnt", n_done, 1);

        // 3: read of top address, data presented at cnt 6
        mcu_req_i = 1; mcu_we_i = 0; mcu_addr_i = 17'h1FFFF; bus_data_i = 8'h00;
        n_done = 0;
        repeat (16) begin
            step();
            cyc(1, 0, 17'h1FFFF, '0, "rd");
            if (m_cnt == 6) begin chk("rd_pre", mcu_rd_data_o, 8'h00); bus_data_i = 8'h3C; end
            if (m_cnt == 7) begin chk("rd_data", mcu_rd_data_o, 8'h3C); bus_data_i = 8'h55; mcu_req_i = 0; end
        end
        chk("rd_hold", mcu_rd_data_o, 8'h3C);
        chk("rd_done_cnt", n_done, 1);

        // 4: request held for three frames
        mcu_req_i = 1; mcu_we_i = 1; mcu_addr_i = 17'h00123; mcu_wr_data_i = 8'h11;
        n_done = 0;
        for (int i = 0; i < 48; i++) begin
            step();
            cyc(1, 1, 17'h00123, 8'h11, "b2b");
            if (mcu_done_o) dpos.push_back(i);
            if (i == 39) mcu_req_i = 0;
        end
        repeat (16) begin step(); cyc(0, 1, '0, '0, "b2b_after"); end
        chk("b2b_done_cnt", n_done, 3);
        if (dpos.size() == 3) begin
            chk("b2b_gap1", dpos[1] - dpos[0], 16);
            chk("b2b_gap2", dpos[2] - dpos[1], 16);
        end else begin
            chk("b2b_pulses", dpos.size(), 3);
        end

        // 5: reset in the middle of a write
        mcu_req_i = 1; mcu_we_i = 1; mcu_addr_i = 17'h0AAAA; mcu_wr_data_i = 8'h5A;
        wait_cnt(4);
        chk("mid_pre_we", ram_we_no, 0);
        reset_ni = 1'b0;
        #1;
        chk("mid_rst_ctl", w_ctl, RST_CTL);
        mcu_req_i = 0;
        repeat (3) begin step(); chk("mid_rst_hold", w_ctl, RST_CTL); end
        reset_ni = 1'b1;
        n_done = 0;
        repeat (16) begin step(); cyc(0, 0, '0, '0, "post_rst"); end
        chk("post_rst_done", n_done, 0);

        // 6: CPU halt request raised at cnt 9
        wait_cnt(9);
        cpu_halt_i = 1;
        exp_rdy = 1;
        for (int i = 0; i < 48; i++) begin
            prev_halt = cpu_halt_i;
            step();
`ifdef CPU_HALT_EN
            if (m_cnt == 0) exp_rdy = !prev_halt;
`endif
            chk("halt_rdy", cpu_ready_o, exp_rdy);
            if (i == 25) cpu_halt_i = 0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
